// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM state encoding,
// synchronizer depth and the minimum clkin/SCK oversample ratio.
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    localparam int SPI_SYNC_STAGES    = 2;
    localparam int SPI_MIN_OVERSAMPLE = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings one asynchronous pin into the clkin domain and derives
// single-cycle rise/fall pulses from the synchronized level.
module spi_sync_edge
    import spi_pkg::*;
(
    input  logic clkin,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SPI_SYNC_STAGES-1:0] sync_reg;
    logic                       hist_reg;

    // Reset to 0 so a pin already low at reset release never looks like a fresh falling edge.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SPI_SYNC_STAGES-2:0], din};
            hist_reg <= sync_reg[SPI_SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SPI_SYNC_STAGES-1];
    assign rise  = level & ~hist_reg;
    assign fall  = ~level & hist_reg;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder oversampling SCK/CSN/MOSI in the clkin domain.
// Define SPI_RESPONDER_LSB_FIRST_EN for LSB-first shifting (default MSB-first).
module spi_responder
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLKIN_HZ   = 100000000,
    parameter int MAX_SCK_HZ = 12500000
) (
    input  logic                            clkin,
    input  logic                            resetn,
    input  logic                            sck,
    input  logic                            csn,
    input  logic                            mosi,
    output logic                            miso,
    output logic                            miso_oe,
    input  logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            tx_req,
    output logic [DATA_WIDTH-1:0]           rx_data,
    output logic                            rx_valid,
    output logic                            frame_active,
    output logic                            frame_abort,
    output logic [$clog2(DATA_WIDTH):0]     bit_count
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

`ifdef SPI_RESPONDER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    generate
        if (CLKIN_HZ / MAX_SCK_HZ < SPI_MIN_OVERSAMPLE) begin : g_ratio_check
            $error("spi_responder: CLKIN_HZ / MAX_SCK_HZ must be at least %0d", SPI_MIN_OVERSAMPLE);
        end
    endgenerate

    // Pin order in the vectors: 0 = sck, 1 = csn, 2 = mosi.
    logic [2:0] pin_raw;
    logic [2:0] pin_level;
    logic [2:0] pin_rise;
    logic [2:0] pin_fall;

    assign pin_raw = {mosi, csn, sck};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pin_sync
            spi_sync_edge u_sync (
                .clkin (clkin),
                .resetn(resetn),
                .din   (pin_raw[gi]),
                .level (pin_level[gi]),
                .rise  (pin_rise[gi]),
                .fall  (pin_fall[gi])
            );
        end
    endgenerate

    logic sck_rise, sck_fall, csn_rise, csn_fall, mosi_s;
    logic unused_sync;

    assign sck_rise    = pin_rise[0];
    assign sck_fall    = pin_fall[0];
    assign csn_rise    = pin_rise[1];
    assign csn_fall    = pin_fall[1];
    assign mosi_s      = pin_level[2];
    assign unused_sync = ^{pin_level[1:0], pin_rise[2], pin_fall[2]};

    spi_state_t            state_reg;
    logic [DATA_WIDTH-1:0] tx_shift_reg;
    logic [DATA_WIDTH-1:0] rx_shift_reg;
    logic [DATA_WIDTH-1:0] rx_data_reg;
    logic [CW-1:0]         bit_count_reg;
    logic                  tx_req_reg;
    logic                  rx_valid_reg;
    logic                  frame_abort_reg;

    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic                  tx_out;
    logic                  last_bit;

    always_comb begin
        rx_next    = {rx_shift_reg[DATA_WIDTH-2:0], mosi_s};
        tx_shifted = {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
        tx_out     = tx_shift_reg[DATA_WIDTH-1];
        if (LSB_FIRST) begin
            rx_next    = {mosi_s, rx_shift_reg[DATA_WIDTH-1:1]};
            tx_shifted = {1'b0, tx_shift_reg[DATA_WIDTH-1:1]};
            tx_out     = tx_shift_reg[0];
        end
    end

    assign last_bit = (bit_count_reg == CW'(DATA_WIDTH - 1));

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            tx_shift_reg    <= '0;
            rx_shift_reg    <= '0;
            rx_data_reg     <= '0;
            bit_count_reg   <= '0;
            tx_req_reg      <= 1'b0;
            rx_valid_reg    <= 1'b0;
            frame_abort_reg <= 1'b0;
        end else begin
            tx_req_reg      <= 1'b0;
            rx_valid_reg    <= 1'b0;
            frame_abort_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (csn_fall) begin
                        tx_shift_reg  <= tx_data;
                        tx_req_reg    <= 1'b1;
                        rx_shift_reg  <= '0;
                        bit_count_reg <= '0;
                        state_reg     <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (csn_rise) begin
                        frame_abort_reg <= (bit_count_reg != '0);
                        bit_count_reg   <= '0;
                        rx_shift_reg    <= '0;
                        state_reg       <= ST_IDLE;
                    end else if (sck_rise) begin
                        if (last_bit) begin
                            rx_data_reg   <= rx_next;
                            rx_valid_reg  <= 1'b1;
                            bit_count_reg <= '0;
                            tx_shift_reg  <= tx_data;
                            tx_req_reg    <= 1'b1;
                        end else begin
                            rx_shift_reg  <= rx_next;
                            bit_count_reg <= bit_count_reg + CW'(1);
                        end
                    end else if (sck_fall && bit_count_reg != '0) begin
                        // A zero count means the word was just (re)loaded and its first bit must stay put.
                        tx_shift_reg <= tx_shifted;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign miso         = (state_reg == ST_ACTIVE) ? tx_out : 1'b0;
    assign miso_oe      = (state_reg == ST_ACTIVE);
    assign frame_active = (state_reg == ST_ACTIVE);
    assign tx_req       = tx_req_reg;
    assign rx_data      = rx_data_reg;
    assign rx_valid     = rx_valid_reg;
    assign frame_abort  = frame_abort_reg;
    assign bit_count    = bit_count_reg;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: table of single-word frames plus
// hand-written multi-word, abort, idle-SCK, reset and back-to-back sequences.
module tb_spi_responder;

`ifdef SPI_RESPONDER_LSB_FIRST_EN
    localparam bit TB_LSB = 1'b1;
`else
    localparam bit TB_LSB = 1'b0;
`endif

    logic       clkin = 1'b0;
    logic       resetn = 1'b0;
    logic       sck = 1'b0;
    logic       csn = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, tx_req, rx_valid, frame_active, frame_abort;
    logic [7:0] rx_data;
    logic [3:0] bit_count;

    spi_responder dut (
        .clkin       (clkin),
        .resetn      (resetn),
        .sck         (sck),
        .csn         (csn),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_active(frame_active),
        .frame_abort (frame_abort),
        .bit_count   (bit_count)
    );

    always #5 clkin = ~clkin;

    int         checks = 0;
    int         failures = 0;
    int         rx_cnt = 0;
    int         tx_req_cnt = 0;
    int         abort_cnt = 0;
    bit         oe_seen = 1'b0;
    logic [7:0] rx_q[$];

    always @(negedge clkin) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_q.push_back(rx_data);
        end
        if (tx_req) tx_req_cnt++;
        if (frame_abort) abort_cnt++;
        if (miso_oe) oe_seen = 1'b1;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clkin);
    endtask

    function automatic int bit_idx(input int i);
        return TB_LSB ? i : 7 - i;
    endfunction

    // Shifts nbits of w on MOSI at SCK = clkin/8; miso_w collects the bit present at each SCK rise.
    task automatic spi_bits(input logic [7:0] w, input int nbits, input logic [7:0] next_tx,
                            output logic [7:0] miso_w, output int txreq_at_last_rise);
        miso_w = 8'h00;
        txreq_at_last_rise = tx_req_cnt;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[bit_idx(i)];
            tick(4);
            if (i == 0) tx_data = next_tx;
            sck = 1'b1;
            miso_w[bit_idx(i)] = miso;
            txreq_at_last_rise = tx_req_cnt;
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic frame_start(input logic [7:0] first_tx);
        tx_data = first_tx;
        csn = 1'b0;
    endtask

    task automatic frame_end();
        tick(4);
        csn = 1'b1;
        tick(8);
        #1;
    endtask

    function automatic logic [7:0] pop_rx();
        if (rx_q.size() == 0) return 8'hxx;
        return rx_q.pop_front();
    endfunction

    typedef struct {
        logic [7:0] mosi_w;
        logic [7:0] tx_w;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] m0, m1, last_rx_exp;
        int         t0, t1, t2, tmid, r0, a0;

        vecs[0] = '{mosi_w: 8'h5A, tx_w: 8'hC3, exp_rx: 8'h5A, exp_miso: 8'hC3};
        vecs[1] = '{mosi_w: 8'h00, tx_w: 8'hFF, exp_rx: 8'h00, exp_miso: 8'hFF};
        vecs[2] = '{mosi_w: 8'hFF, tx_w: 8'h00, exp_rx: 8'hFF, exp_miso: 8'h00};
        vecs[3] = '{mosi_w: 8'h81, tx_w: 8'h7E, exp_rx: 8'h81, exp_miso: 8'h7E};
        vecs[4] = '{mosi_w: 8'h3C, tx_w: 8'hA6, exp_rx: 8'h3C, exp_miso: 8'hA6};

        // Reset state
        tick(3);
        #1;
        check("reset_miso", miso, 0);
        check("reset_miso_oe", miso_oe, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_frame_active", frame_active, 0);
        check("reset_bit_count", bit_count, 0);
        resetn = 1'b1;
        tick(4);

        // Table of single-word frames
        for (int v = 0; v < 5; v++) begin
            rx_q.delete();
            r0 = rx_cnt; t0 = tx_req_cnt; a0 = abort_cnt;
            frame_start(vecs[v].tx_w);
            spi_bits(vecs[v].mosi_w, 8, 8'h00, m0, t1);
            frame_end();
            check("vec_miso", m0, vecs[v].exp_miso);
            check("vec_rx_pulses", rx_cnt - r0, 1);
            check("vec_rx_word", pop_rx(), vecs[v].exp_rx);
            check("vec_rx_data", rx_data, vecs[v].exp_rx);
            check("vec_txreq_consumed", t1 - t0, 1);
            check("vec_txreq_total", tx_req_cnt - t0, 2);
            check("vec_no_abort", abort_cnt - a0, 0);
            $display("vec %0d mosi=%02h tx=%02h rx=%02h miso=%02h", v, vecs[v].mosi_w, vecs[v].tx_w, rx_data, m0);
        end

        // Two-word frame
        rx_q.delete();
        r0 = rx_cnt; t0 = tx_req_cnt;
        frame_start(8'h96);
        spi_bits(8'hA5, 8, 8'h5A, m0, t1);
        spi_bits(8'h3C, 8, 8'h00, m1, t2);
        frame_end();
        check("two_rx_pulses", rx_cnt - r0, 2);
        check("two_rx_word0", pop_rx(), 8'hA5);
        check("two_rx_word1", pop_rx(), 8'h3C);
        check("two_miso_word0", m0, 8'h96);
        check("two_miso_word1", m1, 8'h5A);
        check("two_txreq_consumed", t2 - t0, 2);
        check("two_txreq_total", tx_req_cnt - t0, 3);
        last_rx_exp = 8'h3C;
        $display("two-word frame rx=%02h miso0=%02h miso1=%02h", rx_data, m0, m1);

        // Partial word aborted by CSN
        r0 = rx_cnt; a0 = abort_cnt;
        frame_start(8'h55);
        spi_bits(8'hFF, 5, 8'h00, m0, t1);
        tick(4);
        #1;
        check("partial_bit_count_mid", bit_count, 5);
        csn = 1'b1;
        tick(8);
        #1;
        check("partial_abort", abort_cnt - a0, 1);
        check("partial_no_rx", rx_cnt - r0, 0);
        check("partial_rx_hold", rx_data, last_rx_exp);
        check("partial_bit_count", bit_count, 0);
        check("partial_idle", frame_active, 0);
        $display("partial word abort count=%0d rx=%02h", abort_cnt - a0, rx_data);

        // SCK toggling with CSN high
        r0 = rx_cnt; t0 = tx_req_cnt; oe_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mosi = i[0];
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            tick(4);
        end
        #1;
        check("csnhigh_no_rx", rx_cnt - r0, 0);
        check("csnhigh_no_txreq", tx_req_cnt - t0, 0);
        check("csnhigh_oe", oe_seen, 0);
        $display("csn-high sck burst rx=%0d txreq=%0d", rx_cnt - r0, tx_req_cnt - t0);

        // Reset mid-frame
        frame_start(8'hFF);
        spi_bits(8'hFF, 3, 8'h00, m0, t1);
        tick(2);
        #1;
        check("rstmid_bit_count_before", bit_count, 3);
        check("rstmid_active_before", frame_active, 1);
        resetn = 1'b0;
        #1;
        check("rstmid_miso", miso, 0);
        check("rstmid_miso_oe", miso_oe, 0);
        check("rstmid_tx_req", tx_req, 0);
        check("rstmid_rx_data", rx_data, 0);
        check("rstmid_rx_valid", rx_valid, 0);
        check("rstmid_frame_active", frame_active, 0);
        check("rstmid_frame_abort", frame_abort, 0);
        check("rstmid_bit_count", bit_count, 0);
        tick(3);
        resetn = 1'b1;
        tick(10);
        #1;
        check("rstmid_csn_low_no_start", frame_active, 0);
        csn = 1'b1;
        tick(6);
        rx_q.delete();
        frame_start(8'h00);
        spi_bits(8'h81, 8, 8'h00, m0, t1);
        frame_end();
        check("rstmid_new_rx", rx_data, 8'h81);
        check("rstmid_new_rx_word", pop_rx(), 8'h81);
        $display("reset mid-frame then rx=%02h", rx_data);

        // Bit order: sequence 1,0,1,0,0,1,0,1 gives 0xA5 in either order
        rx_q.delete();
`ifdef SPI_RESPONDER_LSB_FIRST_EN
        frame_start(8'h01);
        spi_bits(8'hA5, 8, 8'h00, m0, t1);
        frame_end();
        check("order_first_miso_bit", m0[0], 1);
        check("order_miso", m0, 8'h01);
`else
        frame_start(8'h80);
        spi_bits(8'hA5, 8, 8'h00, m0, t1);
        frame_end();
        check("order_first_miso_bit", m0[7], 1);
        check("order_miso", m0, 8'h80);
`endif
        check("order_rx", rx_data, 8'hA5);
        $display("bit-order frame rx=%02h miso=%02h", rx_data, m0);

        // Back-to-back frames with CSN high for 4 clkin cycles
        rx_q.delete();
        r0 = rx_cnt; t0 = tx_req_cnt; a0 = abort_cnt;
        frame_start(8'h11);
        spi_bits(8'hC3, 8, 8'h00, m0, t1);
        tick(4);
        csn = 1'b1;
        tick(4);
        tmid = tx_req_cnt;
        frame_start(8'h22);
        spi_bits(8'h5A, 8, 8'h00, m1, t2);
        frame_end();
        check("b2b_rx_pulses", rx_cnt - r0, 2);
        check("b2b_rx_word0", pop_rx(), 8'hC3);
        check("b2b_rx_word1", pop_rx(), 8'h5A);
        check("b2b_miso0", m0, 8'h11);
        check("b2b_miso1", m1, 8'h22);
        check("b2b_txreq_consumed", (t1 - t0) + (t2 - tmid), 2);
        check("b2b_no_abort", abort_cnt - a0, 0);
        $display("back-to-back rx=%02h miso0=%02h miso1=%02h", rx_data, m0, m1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI mode-0 responder (slave) that sits at the far end of the SPI link driven by the team's SPI clock divider and initiator logic. It oversamples an externally supplied SCK, CSN and MOSI in the local `clkin` domain. It shifts in MOSI words on SCK rising edges and drives MISO on SCK falling edges. Parallel words are exchanged with local logic through one-cycle strobes.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per SPI word.
- `CLKIN_HZ`, 100000000: local clock frequency.
- `MAX_SCK_HZ`, 12500000: highest SCK the block must accept.
  - Elaboration fails unless `CLKIN_HZ / MAX_SCK_HZ >= 8`.

Ports:
- `clkin` input 1: local clock. The block has one clock.
- `resetn` input 1: asynchronous, active-low reset.
- `sck` input 1: SPI clock pin. Asynchronous to `clkin`.
- `csn` input 1: SPI chip select pin, active low. Asynchronous to `clkin`.
- `mosi` input 1: SPI data from the initiator. Asynchronous to `clkin`.
- `miso` output 1: SPI data to the initiator.
- `miso_oe` output 1: high while a frame is active. Used for a tri-state pad.
- `tx_data` input DATA_WIDTH: next word to transmit.
- `tx_req` output 1: one-cycle pulse. Marks the cycle `tx_data` was consumed.
- `rx_data` output DATA_WIDTH: last fully received word.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `frame_active` output 1: synchronized `csn` is low.
- `frame_abort` output 1: one-cycle pulse when `csn` rises mid-word.
- `bit_count` output $clog2(DATA_WIDTH)+1: bits received in the current word.

## Operation
- Input synchronization:
  - `sck`, `csn` and `mosi` each pass through a 2-flop synchronizer, then one history flop.
  - Edges are derived from the synchronized value and its history flop.
- State machine, two states:
  - **IDLE**: `frame_active=0`, `miso_oe=0`, `miso=0`. SCK edges are ignored.
    - On the synchronized `csn` falling edge: load `tx_data` into the TX shift register, pulse `tx_req`, set `bit_count=0`, go to ACTIVE.
  - **ACTIVE**: `miso` is the TX shift register's output bit (MSB by default).
    - On an SCK rising edge: shift the synchronized `mosi` into the RX shift register and increment `bit_count`.
    - When `bit_count` reaches DATA_WIDTH:
      - the same cycle loads `rx_data` and pulses `rx_valid`;
      - `bit_count` returns to 0;
      - the TX register reloads from `tx_data` and `tx_req` pulses.
    - On an SCK falling edge: shift the TX register, unless a word boundary just reloaded it.
  - **ACTIVE → IDLE**: on the synchronized `csn` rising edge.
    - If `bit_count != 0`, pulse `frame_abort`, discard the partial RX bits and leave `rx_data` unchanged.
- `tx_data` handshake: upstream must present the next word before the next word boundary, one full word time after `tx_req`. Words are never stalled.
- Simultaneous events:
  - A `csn` rise in the same cycle as an SCK edge: the `csn` rise wins and the SCK edge is ignored.
  - A `csn` fall with SCK high (mode violation): accepted. The first rising edge counts as bit 0.
- Reset, asynchronous and effective mid-frame:
  - All outputs go to 0 and the state goes to IDLE.
  - The block waits for a fresh `csn` falling edge; a `csn` already low at reset release does not start a frame.

## Timing
- A pin edge is acted on 3 `clkin` cycles after it arrives (2 synchronizer flops + 1 edge flop).
- `miso` changes 3–4 `clkin` cycles after the SCK falling edge. This satisfies mode-0 setup when SCK half-period ≥ 4 `clkin` cycles.
- The first `miso` bit is valid 4 `clkin` cycles after the `csn` fall.
- `rx_valid` fires 4 `clkin` cycles after the last SCK rising edge of a word.
- Reset values: `miso`=0, `miso_oe`=0, `tx_req`=0, `rx_data`=0, `rx_valid`=0, `frame_active`=0, `frame_abort`=0, `bit_count`=0.

## Configuration
- `SPI_RESPONDER_LSB_FIRST_EN`:
  - **Defined**: both shift registers operate LSB-first. `rx_data` bit 0 is the first bit received; `miso` starts with `tx_data[0]`.
  - **Undefined**: MSB-first, the SPI default.

## Structure
- Shared package `spi_pkg` holds:
  - the ACTIVE/IDLE state enum;
  - the `SPI_SYNC_STAGES=2` constant;
  - the minimum oversample ratio constant (8).
- Sub-module `spi_sync_edge`: a 2-flop synchronizer plus history flop per signal. Outputs the synchronized level, a rise pulse and a fall pulse. It is instantiated three times.

## Test plan
- **Two-word frame.** SCK = clkin/8. MOSI sends 0xA5 then 0x3C; `tx_data` is 0x96, then 0x5A after the first `tx_req`.
  - Required: `rx_valid` twice, with `rx_data` 0xA5 then 0x3C.
  - Required: MISO samples 0x96 then 0x5A; `tx_req` pulses 2 times.
- **Partial word.** `csn` rises after 5 SCK rising edges.
  - Required: `frame_abort` pulses once, no `rx_valid`, `rx_data` holds its previous value, `bit_count` returns to 0.
- **CSN high.** 16 SCK pulses with `csn` high.
  - Required: no `rx_valid`, no `tx_req`, `miso_oe` stays 0.
- **Reset mid-frame.** Assert `resetn` after 3 bits.
  - Required: all outputs 0 within the same cycle.
  - Required: after release, a new frame with MOSI 0x81 produces `rx_data`=0x81.
- **LSB-first build.** With `SPI_RESPONDER_LSB_FIRST_EN`, MOSI bit sequence 1,0,1,0,0,1,0,1 yields `rx_data`=0xA5.
  - Required: `tx_data`=0x01 puts 1 on the first MISO bit.
- **Back-to-back frames.** `csn` high for exactly 4 `clkin` cycles between two 1-word frames.
  - Required: both words received and 2 `tx_req` pulses.
